// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux41 operand sequencer: FSM states and default sizes.
package mux_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mux_operand_seq.sv
// Generates n_pairs arithmetic operand pairs for a mux41 stage, presenting each pair
// on four consecutive accepted beats with a rotating select, then pulses done.
module mux_operand_seq
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_init,
  input  logic [WIDTH-1:0] b_init,
  input  logic [WIDTH-1:0] a_step,
  input  logic [WIDTH-1:0] b_step,
  input  logic [CNT_W-1:0] n_pairs,
  input  logic             ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [1:0]       sel_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output state_t           o_dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_out;
  logic [WIDTH-1:0] r_b_out;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_a_step;
  logic [WIDTH-1:0] r_b_step;
  logic [CNT_W-1:0] r_n_pairs;
  logic [CNT_W-1:0] r_pair_cnt;
  logic [1:0]       r_beat_cnt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [1:0]       w_sel_nxt;
  logic [WIDTH-1:0] w_a_step_nxt;
  logic [WIDTH-1:0] w_b_step_nxt;
  logic [CNT_W-1:0] w_n_pairs_nxt;
  logic [CNT_W-1:0] w_pair_nxt;
  logic [1:0]       w_beat_nxt;
  logic             w_accept;

  // Handshake: a beat transfers on a cycle where valid && ready are both high;
  // while valid is high and ready is low, a_out/b_out/sel_out stay stable.
  assign valid       = (r_state == ST_RUN);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign a_out       = r_a_out;
  assign b_out       = r_b_out;
  assign sel_out     = r_sel;
  assign o_dbg_state = r_state;
  assign w_accept    = valid && ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a_out;
    w_b_nxt       = r_b_out;
    w_sel_nxt     = r_sel;
    w_a_step_nxt  = r_a_step;
    w_b_step_nxt  = r_b_step;
    w_n_pairs_nxt = r_n_pairs;
    w_pair_nxt    = r_pair_cnt;
    w_beat_nxt    = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_step_nxt  = a_step;
          w_b_step_nxt  = b_step;
          w_n_pairs_nxt = n_pairs;
          w_pair_nxt    = '0;
          w_beat_nxt    = '0;
          // An empty request goes straight to DONE without touching the operands.
          if (n_pairs == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_a_nxt     = a_init + a_step;
            w_b_nxt     = b_init + b_step;
            w_sel_nxt   = r_sel + 2'd1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_sel_nxt  = r_sel + 2'd1;
          w_beat_nxt = r_beat_cnt + 2'd1;
          if (r_beat_cnt == 2'd3) begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_pair_cnt == r_n_pairs - CNT_ONE) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_a_nxt     = r_a_out + r_a_step;
          w_b_nxt     = r_b_out + r_b_step;
          w_pair_nxt  = r_pair_cnt + CNT_ONE;
          w_beat_nxt  = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_a_out    <= '0;
      r_b_out    <= '0;
      r_sel      <= '0;
      r_a_step   <= '0;
      r_b_step   <= '0;
      r_n_pairs  <= '0;
      r_pair_cnt <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_a_out    <= w_a_nxt;
      r_b_out    <= w_b_nxt;
      r_sel      <= w_sel_nxt;
      r_a_step   <= w_a_step_nxt;
      r_b_step   <= w_b_step_nxt;
      r_n_pairs  <= w_n_pairs_nxt;
      r_pair_cnt <= w_pair_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

endmodule

// File: doc/mux_operand_seq.md
MUX_OPERAND_SEQ -- requirements
Module: mux_operand_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand width of a_init/b_init/a_step/b_step/a_out/b_out.
REQ-002 SHALL have parameter CNT_W, default 8, giving width of n_pairs and the internal pair counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-007 a_init  input  WIDTH  base operand A, captured on accepted start.
REQ-008 b_init  input  WIDTH  base operand B, captured on accepted start.
REQ-009 a_step  input  WIDTH  per-pair increment for A, captured on accepted start.
REQ-010 b_step  input  WIDTH  per-pair increment for B, captured on accepted start.
REQ-011 n_pairs  input  CNT_W  number of operand pairs, captured on accepted start.
REQ-012 ready  input  1  downstream mux41 stage accepts the current beat.
REQ-013 a_out  output  WIDTH  operand A to mux41.
REQ-014 b_out  output  WIDTH  operand B to mux41.
REQ-015 sel_out  output  2  select to mux41.
REQ-016 valid  output  1  a_out/b_out/sel_out form a valid beat.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at sequence end.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, GAP, DONE.
REQ-020 IDLE, start=1: capture all inputs; a_out<=a_init+a_step, b_out<=b_init+b_step, sel_out<=sel_out+1, pair_cnt<=0, beat_cnt<=0; go RUN (n_pairs=0: go DONE, no operand/select update).
REQ-021 RUN: valid=1; beat accepted when valid&&ready; each accept: sel_out<=sel_out+1 (mod 4), beat_cnt<=beat_cnt+1.
REQ-022 RUN, valid&&!ready: a_out, b_out, sel_out, beat_cnt SHALL hold unchanged.
REQ-023 RUN, 4th accepted beat (beat_cnt=3): go GAP; sel_out back at first pair value +4 mod 4.
REQ-024 GAP: valid=0 for exactly one cycle; if pair_cnt=n_pairs-1 go DONE, else a_out<=a_out+a_step, b_out<=b_out+b_step, pair_cnt+1, beat_cnt<=0, go RUN.
REQ-025 DONE: done=1, valid=0 for one cycle; go IDLE.
REQ-026 All additions SHALL be modulo 2^WIDTH (wrap, no saturation, no flag).
REQ-027 start outside IDLE SHALL be ignored with no effect on state or outputs.
REQ-028 IDLE and DONE: a_out/b_out/sel_out hold last values; valid=0.
REQ-029 Latency: first beat valid one cycle after accepted start.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, a_out=0, b_out=0, sel_out=0, valid=0, busy=0, done=0, counters 0, from any state including mid-RUN.
REQ-031 rst SHALL take priority over start in the same cycle.

Structure
REQ-032 Shared package mux_seq_pkg SHALL hold the FSM state enumeration and default WIDTH/CNT_W constants.
REQ-033 Single module, no sub-modules; output feeds mux41 A/B/S directly.

Verification
REQ-034 a_init=5, b_init=22, a_step=10, b_step=11, n_pairs=5, ready=1, start at cycle 0 -> cycles 1-4: A=15, B=33, sel 1,2,3,0; cycles 21-24: A=55, B=77; done=1 only at cycle 26.
REQ-035 As REQ-034, ready=0 cycles 2-4 -> A=15, B=33, sel=2 held cycles 2-5; pair-1 beats complete cycle 7.
REQ-036 a_init=32'hFFFF_FFF0, a_step=32'h20, n_pairs=2 -> A=32'h10 then 32'h30; no error.
REQ-037 n_pairs=0, start -> valid never high; done=1 at cycle 1; busy high cycle 1 only.
REQ-038 rst=1 in cycle 7 of REQ-034 run -> cycle 8: IDLE, all outputs 0; start at cycle 9 restarts sequence from captured new inputs.
REQ-039 start pulsed at cycle 3 during run -> sequence identical to REQ-034.
